// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants, state encoding and digit-blanking helper for the
// sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

    localparam int unsigned BIN_W   = 10;
    localparam int unsigned DIGITS  = 3;
    localparam int unsigned BCD_MAX = 999;
    localparam int unsigned BCD_W   = 4 * DIGITS;
    localparam int unsigned CNT_W   = 4;

    localparam logic [3:0]       DIGIT_BLANK = 4'hA;
    localparam logic [BIN_W-1:0] BIN_MAX     = BIN_W'(BCD_MAX);
    localparam logic [CNT_W-1:0] SHIFT_LAST  = CNT_W'(BIN_W - 1);
    localparam logic [BCD_W-1:0] BCD_BLANK   = {DIGITS{DIGIT_BLANK}};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Units digit is never blanked; tens only when hundreds is also zero.
    function automatic logic [BCD_W-1:0] blank_digits(input logic [BCD_W-1:0] d,
                                                      input logic en);
        logic [BCD_W-1:0] r;
        r = d;
        if (en) begin
            if (d[11:8] == 4'd0) r[11:8] = DIGIT_BLANK;
            if (d[11:4] == 8'd0) r[7:4]  = DIGIT_BLANK;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Double-dabble digit adjust: add 3 to a BCD digit that is 5 or more.
module bcd_add3 (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential 10-bit binary to 3-digit BCD converter (double dabble),
// fixed 11-cycle latency, with saturation and leading-zero blanking.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [BIN_W-1:0]     bin,
    input  logic                 blank_lz,
    output logic                 busy,
    output logic                 done,
    output logic [BCD_W-1:0]     bcd,
    output logic                 ovf,
    output logic                 disp_en
);

    logic [1:0]             r_state;
    logic [BIN_W-1:0]       r_opnd;
    logic [BCD_W-1:0]       r_scr;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_blank;
    logic                   r_ovf_cap;
    logic                   r_busy;
    logic                   r_done;
    logic [BCD_W-1:0]       r_bcd;
    logic                   r_ovf;
    logic                   r_disp_en;

    logic [BCD_W-1:0]       w_adj;
    logic [BCD_W+BIN_W-1:0] w_shift;
    logic                   w_ovf;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3 u_add3 (
            .i_digit (r_scr[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
        );
    end

    // {scratch, operand} shifted left once, using the adjusted digits.
    assign w_shift = {w_adj[BCD_W-2:0], r_opnd, 1'b0};
    assign w_ovf   = (bin > BIN_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_opnd    <= '0;
            r_scr     <= '0;
            r_cnt     <= '0;
            r_blank   <= 1'b0;
            r_ovf_cap <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= BCD_BLANK;
            r_ovf     <= 1'b0;
            r_disp_en <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_opnd    <= w_ovf ? BIN_MAX : bin;
                        r_ovf_cap <= w_ovf;
                        r_blank   <= blank_lz;
                        r_scr     <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_scr  <= w_shift[BCD_W+BIN_W-1:BIN_W];
                    r_opnd <= w_shift[BIN_W-1:0];
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == SHIFT_LAST) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_bcd     <= blank_digits(r_scr, r_blank);
                    r_ovf     <= r_ovf_cap;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_disp_en <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign bcd     = r_bcd;
    assign ovf     = r_ovf;
    assign disp_en = r_disp_en;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: expected results are queued at start
// and compared, with latency, when done pulses.
module tb_bin2bcd_seq;

    typedef struct {
        logic [11:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  bin;
    logic        blank_lz;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic        ovf;
    logic        disp_en;

    exp_t q[$];
    int   n_chk;
    int   n_pass;
    int   cyc;
    int   n_done;
    logic prev_done;

    bin2bcd_seq u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin      (bin),
        .blank_lz (blank_lz),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .ovf      (ovf),
        .disp_en  (disp_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    function automatic exp_t model(input int b, input logic blz);
        exp_t e;
        int v, h, t, u;
        v = (b > 999) ? 999 : b;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        e.ovf = (b > 999);
        e.bcd = {4'(h), 4'(t), 4'(u)};
        if (blz && h == 0) begin
            e.bcd[11:8] = 4'hA;
            if (t == 0) e.bcd[7:4] = 4'hA;
        end
        e.cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            n_done++;
            check("done_pulse_width", 32'(prev_done), 0);
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                check("bcd", 32'(bcd), 32'(e.bcd));
                check("ovf", 32'(ovf), 32'(e.ovf));
                check("latency", 32'(cyc - e.cyc), 11);
                check("disp_en_set", 32'(disp_en), 1);
            end
        end
        prev_done = done;
    end

    // Caller must be between edges; start is sampled at the next rising edge.
    task automatic drive_start(input int b, input logic blz, input bit push);
        exp_t e;
        start    = 1'b1;
        bin      = 10'(b);
        blank_lz = blz;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            e     = model(b, blz);
            e.cyc = cyc;
            q.push_back(e);
        end
    endtask

    task automatic convert(input int b, input logic blz);
        @(negedge clk);
        drive_start(b, blz, 1'b1);
        check("busy_after_start", 32'(busy), 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (!busy && !done) ok = 1'b1;
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        if (!ok) check("done_timeout", 0, 1);
    endtask

    initial begin
        int d0;
        n_chk     = 0;
        n_pass    = 0;
        cyc       = 0;
        n_done    = 0;
        prev_done = 1'b0;
        start     = 1'b0;
        bin       = '0;
        blank_lz  = 1'b0;
        rst_n     = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_disp_en", 32'(disp_en), 0);
        check("rst_bcd", 32'(bcd), 32'h0AAA);
        rst_n = 1'b1;

        // First start right after release must be accepted.
        drive_start(0, 1'b0, 1'b1);
        wait_idle();
        convert(0, 1'b1);    wait_idle();
        convert(57, 1'b1);   wait_idle();
        convert(305, 1'b1);  wait_idle();
        convert(999, 1'b0);  wait_idle();
        convert(1023, 1'b0); wait_idle();
        convert(5, 1'b0);    wait_idle();
        convert(5, 1'b1);    wait_idle();
        convert(1023, 1'b1); wait_idle();
        convert(40, 1'b1);   wait_idle();
        check("bcd_hold", 32'(bcd), 32'h0A40);

        // Start while busy is ignored; start on the edge after done is taken.
        d0 = n_done;
        convert(123, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        drive_start(456, 1'b0, 1'b0);
        wait_done();
        drive_start(456, 1'b0, 1'b1);
        wait_idle();
        check("busy_ignore_done_count", 32'(n_done - d0), 2);

        // Asynchronous reset in the middle of a conversion.
        convert(777, 1'b1);
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_bcd", 32'(bcd), 32'h0AAA);
        check("midrst_disp_en", 32'(disp_en), 0);
        q.delete();
        d0 = n_done;
        repeat (3) @(negedge clk);
        check("midrst_no_done", 32'(n_done - d0), 0);
        rst_n = 1'b1;
        drive_start(640, 1'b1, 1'b1);
        wait_idle();
        convert(8, 1'b1);
        wait_idle();

        check("scoreboard_empty", 32'(q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
